// File: rtl/ct_mmu_sysmap_arb.sv
// Sysmap lookup front-end: round-robin PTW/JTLB arbiter, registered page number
// to the sysmap comparators, and a one-entry response buffer for the flag/hit result.
module ct_mmu_sysmap_arb #(
    parameter int unsigned PA_WIDTH  = 40,
    parameter int unsigned FLG_WIDTH = 5,
    parameter int unsigned ENTRY_NUM = 8
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic                   ptw_sysmap_req_vld,
    input  logic [PA_WIDTH-13:0]   ptw_sysmap_req_pa,
    output logic                   ptw_sysmap_req_rdy,
    input  logic                   jtlb_sysmap_req_vld,
    input  logic [PA_WIDTH-13:0]   jtlb_sysmap_req_pa,
    output logic                   jtlb_sysmap_req_rdy,
    output logic [PA_WIDTH-13:0]   mmu_sysmap_pa_y,
    input  logic [FLG_WIDTH-1:0]   sysmap_mmu_flg_y,
    input  logic [ENTRY_NUM-1:0]   sysmap_mmu_hit_y,
    input  logic                   sysmap_flush,
    output logic                   sysmap_rsp_vld,
    input  logic                   sysmap_rsp_rdy,
    output logic                   sysmap_rsp_id,
    output logic [FLG_WIDTH-1:0]   sysmap_rsp_flg,
    output logic [2:0]             sysmap_rsp_hit_idx,
    output logic                   sysmap_rsp_miss
);

    localparam int unsigned PPN_W = PA_WIDTH - 12;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_rr_ptr;
    logic               r_req_id;

    logic               w_grant_ok;
    logic               w_pick_jtlb;
    logic               w_ptw_gnt;
    logic               w_jtlb_gnt;
    logic               w_gnt;
    logic               w_contest;
    logic [PPN_W-1:0]   w_gnt_pa;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_miss;

    // A grant slot exists in IDLE, or in RESP when the buffered response drains this cycle.
    assign w_grant_ok  = !cpurst && !sysmap_flush &&
                         ((r_state == IDLE) || ((r_state == RESP) && sysmap_rsp_rdy));
    assign w_pick_jtlb = jtlb_sysmap_req_vld && (!ptw_sysmap_req_vld || r_rr_ptr);
    assign w_ptw_gnt   = w_grant_ok && ptw_sysmap_req_vld && !w_pick_jtlb;
    assign w_jtlb_gnt  = w_grant_ok && w_pick_jtlb;
    assign w_gnt       = w_ptw_gnt || w_jtlb_gnt;
    assign w_contest   = w_grant_ok && ptw_sysmap_req_vld && jtlb_sysmap_req_vld;
    assign w_gnt_pa    = w_pick_jtlb ? jtlb_sysmap_req_pa : ptw_sysmap_req_pa;

    assign ptw_sysmap_req_rdy  = w_ptw_gnt;
    assign jtlb_sysmap_req_rdy = w_jtlb_gnt;

    // Lowest set hit bit wins; scanning downward lets the lowest index overwrite last.
    always_comb begin
        w_hit_idx = '0;
        w_miss    = 1'b1;
        for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--) begin
            if (sysmap_mmu_hit_y[i]) begin
                w_hit_idx = IDX_W'(i);
                w_miss    = 1'b0;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state            <= IDLE;
            r_rr_ptr           <= 1'b0;
            r_req_id           <= 1'b0;
            mmu_sysmap_pa_y    <= '0;
            sysmap_rsp_vld     <= 1'b0;
            sysmap_rsp_id      <= 1'b0;
            sysmap_rsp_flg     <= '0;
            sysmap_rsp_hit_idx <= '0;
            sysmap_rsp_miss    <= 1'b0;
        end else begin
            if (w_contest) begin
                r_rr_ptr <= ~r_rr_ptr;
            end
            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        mmu_sysmap_pa_y <= w_gnt_pa;
                        r_req_id        <= w_pick_jtlb;
                        r_state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (sysmap_flush) begin
                        r_state <= IDLE;
                    end else begin
                        sysmap_rsp_vld     <= 1'b1;
                        sysmap_rsp_id      <= r_req_id;
                        sysmap_rsp_flg     <= sysmap_mmu_flg_y;
                        sysmap_rsp_hit_idx <= w_hit_idx;
                        sysmap_rsp_miss    <= w_miss;
                        r_state            <= RESP;
                    end
                end
                RESP: begin
                    // Flush drops the buffer; w_gnt is already suppressed under flush.
                    if (sysmap_flush || sysmap_rsp_rdy) begin
                        sysmap_rsp_vld <= 1'b0;
                        if (w_gnt) begin
                            mmu_sysmap_pa_y <= w_gnt_pa;
                            r_req_id        <= w_pick_jtlb;
                            r_state         <= LOOKUP;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_mmu_sysmap_arb.sv
// Self-checking bench for ct_mmu_sysmap_arb: vector table, alternation, flush and reset sequences.
module tb_ct_mmu_sysmap_arb;

    typedef struct packed {
        logic       id;
        logic [4:0] flg;
        logic [2:0] idx;
        logic       miss;
    } exp_t;

    typedef struct {
        logic        jtlb;
        logic [27:0] pa;
        logic [4:0]  flg;
        logic [7:0]  hit;
        logic [2:0]  exp_idx;
        logic        exp_miss;
        int          stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        cpurst = 1'b1;
    logic        ptw_vld = 1'b0;
    logic [27:0] ptw_pa = '0;
    logic        ptw_rdy;
    logic        jtlb_vld = 1'b0;
    logic [27:0] jtlb_pa = '0;
    logic        jtlb_rdy;
    logic [27:0] pa_y;
    logic [4:0]  flg_y;
    logic [7:0]  hit_y;
    logic        flush = 1'b0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic        rsp_id;
    logic [4:0]  rsp_flg;
    logic [2:0]  rsp_idx;
    logic        rsp_miss;

    logic        use_model = 1'b0;
    logic [4:0]  drv_flg = '0;
    logic [7:0]  drv_hit = '0;
    logic [4:0]  cur_flg = '0;
    logic [2:0]  cur_idx = '0;
    logic        cur_miss = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    vec_t        vecs[7];

    always #5 clk = ~clk;

    // Stand-in for the sysmap comparators: either bench-driven or derived from the page number.
    assign flg_y = use_model ? pa_y[4:0]  : drv_flg;
    assign hit_y = use_model ? pa_y[12:5] : drv_hit;

    ct_mmu_sysmap_arb #(.PA_WIDTH(40), .FLG_WIDTH(5), .ENTRY_NUM(8)) dut (
        .forever_cpuclk      (clk),
        .cpurst              (cpurst),
        .ptw_sysmap_req_vld  (ptw_vld),
        .ptw_sysmap_req_pa   (ptw_pa),
        .ptw_sysmap_req_rdy  (ptw_rdy),
        .jtlb_sysmap_req_vld (jtlb_vld),
        .jtlb_sysmap_req_pa  (jtlb_pa),
        .jtlb_sysmap_req_rdy (jtlb_rdy),
        .mmu_sysmap_pa_y     (pa_y),
        .sysmap_mmu_flg_y    (flg_y),
        .sysmap_mmu_hit_y    (hit_y),
        .sysmap_flush        (flush),
        .sysmap_rsp_vld      (rsp_vld),
        .sysmap_rsp_rdy      (rsp_rdy),
        .sysmap_rsp_id       (rsp_id),
        .sysmap_rsp_flg      (rsp_flg),
        .sysmap_rsp_hit_idx  (rsp_idx),
        .sysmap_rsp_miss     (rsp_miss)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_idx(input logic [7:0] h);
        logic found;
        found   = 1'b0;
        ref_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (h[i] && !found) begin
                ref_idx = 3'(i);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic exp_t mk_exp(input logic id, input logic [27:0] pa);
        exp_t e;
        e.id = id;
        if (use_model) begin
            e.flg  = pa[4:0];
            e.idx  = ref_idx(pa[12:5]);
            e.miss = (pa[12:5] == 8'h00);
        end else begin
            e.flg  = cur_flg;
            e.idx  = cur_idx;
            e.miss = cur_miss;
        end
        return e;
    endfunction

    // Scoreboard: push on request accept, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!cpurst) begin
            if (rsp_vld && rsp_rdy) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got id=%0d flg=0x%0h, expected no response at %0t",
                             rsp_id, rsp_flg, $time);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_payload", 64'({rsp_id, rsp_flg, rsp_idx, rsp_miss}), 64'(e));
                end
            end
            if (ptw_vld && ptw_rdy)   sb.push_back(mk_exp(1'b0, ptw_pa));
            if (jtlb_vld && jtlb_rdy) sb.push_back(mk_exp(1'b1, jtlb_pa));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_env(input logic [4:0] f, input logic [7:0] h, input logic [2:0] ei,
                           input logic em);
        drv_flg  = f;
        drv_hit  = h;
        cur_flg  = f;
        cur_idx  = ei;
        cur_miss = em;
    endtask

    // Returns one step past the accepting edge (state LOOKUP).
    task automatic wait_accept(input logic jt, input string name);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (jt ? jtlb_rdy : ptw_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
        tick();
    endtask

    task automatic do_reset();
        cpurst   = 1'b1;
        ptw_vld  = 1'b1;
        jtlb_vld = 1'b1;
        rsp_rdy  = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", 64'({ptw_rdy, jtlb_rdy}), 64'd0);
        tick();
        cpurst   = 1'b0;
        ptw_vld  = 1'b0;
        jtlb_vld = 1'b0;
        sb.delete();
        chk("reset_outputs", 64'({pa_y, rsp_vld, rsp_id, rsp_flg, rsp_idx, rsp_miss}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 28'h0000123, 5'b01111, 8'h04, 3'd2, 1'b0, 0};
        vecs[1] = '{1'b1, 28'h0000456, 5'b10101, 8'h00, 3'd0, 1'b1, 5};
        vecs[2] = '{1'b0, 28'h0000ABC, 5'b00001, 8'hA0, 3'd5, 1'b0, 0};
        vecs[3] = '{1'b1, 28'hFFFFFFF, 5'b11111, 8'h80, 3'd7, 1'b0, 0};
        vecs[4] = '{1'b0, 28'h0000000, 5'b00000, 8'h01, 3'd0, 1'b0, 2};
        vecs[5] = '{1'b1, 28'h5555555, 5'b01010, 8'hFF, 3'd0, 1'b0, 0};
        vecs[6] = '{1'b0, 28'hA5A5A5A, 5'b10000, 8'h18, 3'd3, 1'b0, 1};

        do_reset();

        // Single-requester transactions with latency, stall and payload-hold checks.
        for (int v = 0; v < 7; v++) begin
            set_env(vecs[v].flg, vecs[v].hit, vecs[v].exp_idx, vecs[v].exp_miss);
            rsp_rdy = (vecs[v].stall == 0);
            if (vecs[v].jtlb) begin jtlb_vld = 1'b1; jtlb_pa = vecs[v].pa; end
            else              begin ptw_vld  = 1'b1; ptw_pa  = vecs[v].pa; end
            wait_accept(vecs[v].jtlb, "vec_accept");
            ptw_vld  = 1'b0;
            jtlb_vld = 1'b0;
            chk("vec_lookup", 64'({pa_y, rsp_vld}), 64'({vecs[v].pa, 1'b0}));
            tick();
            chk("vec_rsp_t2", 64'(rsp_vld), 64'd1);
            if (vecs[v].stall > 0) begin
                ptw_vld  = 1'b1;
                jtlb_vld = 1'b1;
                for (int s = 0; s < vecs[v].stall; s++) begin
                    @(negedge clk);
                    chk("vec_stall_hold",
                        64'({rsp_vld, ptw_rdy, jtlb_rdy, rsp_id, rsp_flg, rsp_idx, rsp_miss}),
                        64'({3'b100, vecs[v].jtlb, vecs[v].flg, vecs[v].exp_idx, vecs[v].exp_miss}));
                end
                tick();
                ptw_vld  = 1'b0;
                jtlb_vld = 1'b0;
                rsp_rdy  = 1'b1;
            end
            tick();
            chk("vec_rsp_done", 64'(rsp_vld), 64'd0);
        end
        chk("vec_sb_empty", 64'(sb.size()), 64'd0);

        // Both requesters every cycle: alternate grants, one response per two cycles.
        do_reset();
        use_model = 1'b1;
        ptw_pa    = 28'h0000183;
        jtlb_pa   = 28'h000001F;
        rsp_rdy   = 1'b1;
        ptw_vld   = 1'b1;
        jtlb_vld  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 2 == 0)
                chk("alt_cycle", 64'({ptw_rdy, jtlb_rdy, rsp_vld}),
                    64'({((k / 2) % 2 == 0), ((k / 2) % 2 == 1), (k > 0)}));
            else
                chk("alt_cycle", 64'({ptw_rdy, jtlb_rdy, rsp_vld}), 64'd0);
        end
        tick();
        ptw_vld  = 1'b0;
        jtlb_vld = 1'b0;
        repeat (3) tick();
        chk("alt_drain", 64'(sb.size()), 64'd0);
        use_model = 1'b0;

        // Flush during LOOKUP discards the in-flight lookup.
        set_env(5'h03, 8'h02, 3'd1, 1'b0);
        ptw_pa  = 28'h0000777;
        ptw_vld = 1'b1;
        wait_accept(1'b0, "flush_lk_accept");
        ptw_vld = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_lk_no_rsp", 64'(rsp_vld), 64'd0);
        chk("flush_lk_inflight", 64'(sb.size()), 64'd1);
        sb.delete();
        tick();
        chk("flush_lk_still_idle", 64'(rsp_vld), 64'd0);

        // Flush in IDLE blocks the grant.
        jtlb_vld = 1'b1;
        jtlb_pa  = 28'h0000321;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_idle_block", 64'(jtlb_rdy), 64'd0);
        tick();
        flush   = 1'b0;
        rsp_rdy = 1'b0;
        set_env(5'h15, 8'h40, 3'd6, 1'b0);
        wait_accept(1'b1, "flush_hs_accept");
        jtlb_vld = 1'b0;
        tick();
        chk("flush_hs_resp", 64'(rsp_vld), 64'd1);

        // Flush coincident with the handshake: response consumed, pending PTW not granted.
        rsp_rdy = 1'b1;
        flush   = 1'b1;
        ptw_vld = 1'b1;
        ptw_pa  = 28'h0000999;
        @(negedge clk);
        chk("flush_hs_no_grant", 64'(ptw_rdy), 64'd0);
        tick();
        flush = 1'b0;
        set_env(5'h01, 8'h00, 3'd0, 1'b1);
        chk("flush_hs_vld_low", 64'(rsp_vld), 64'd0);
        chk("flush_hs_consumed", 64'(sb.size()), 64'd0);
        @(negedge clk);
        chk("flush_hs_idle_grant", 64'(ptw_rdy), 64'd1);
        tick();
        ptw_vld = 1'b0;
        repeat (3) tick();
        chk("flush_hs_drain", 64'(sb.size()), 64'd0);

        // Reset while in RESP with the pointer advanced.
        do_reset();
        set_env(5'h0C, 8'h10, 3'd4, 1'b0);
        ptw_pa   = 28'h0000ACE;
        jtlb_pa  = 28'h0000BDF;
        ptw_vld  = 1'b1;
        jtlb_vld = 1'b1;
        rsp_rdy  = 1'b0;
        wait_accept(1'b0, "rst_contest_ptw");
        tick();
        chk("rst_in_resp", 64'(rsp_vld), 64'd1);
        cpurst = 1'b1;
        @(negedge clk);
        chk("rst_rdy_low", 64'({ptw_rdy, jtlb_rdy}), 64'd0);
        tick();
        cpurst = 1'b0;
        chk("rst_mid_outputs", 64'({pa_y, rsp_vld, rsp_id, rsp_flg, rsp_idx, rsp_miss}), 64'd0);
        chk("rst_mid_inflight", 64'(sb.size()), 64'd1);
        sb.delete();
        @(negedge clk);
        chk("rst_ptr_cleared", 64'({ptw_rdy, jtlb_rdy}), 64'b10);
        tick();
        ptw_vld  = 1'b0;
        jtlb_vld = 1'b0;
        rsp_rdy  = 1'b1;
        repeat (3) tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_mmu_sysmap_arb.md
# ct_mmu_sysmap_arb

Request front-end for the MMU sysmap attribute lookup. Arbitrates between the PTW and JTLB-refill requesters and registers the selected physical page number onto the sysmap compare inputs. It captures the combinational flag/hit result one cycle later and holds it in a one-entry response buffer until the consumer accepts it. It sits directly upstream of the sysmap comparator block and drives its `mmu_sysmap_pa_y` input.

## Interface
- PA_WIDTH, 40, physical address width; page number width PPN_W = PA_WIDTH-12 (28).
- FLG_WIDTH, 5, sysmap attribute flag width.
- ENTRY_NUM, 8, number of sysmap regions (hit vector width).

- forever_cpuclk  in  1  single clock, all state on rising edge.
- cpurst  in  1  reset: synchronous, active-high.
- ptw_sysmap_req_vld  in  1  PTW request valid.
- ptw_sysmap_req_pa  in  PPN_W  PTW page number.
- ptw_sysmap_req_rdy  out  1  PTW request accepted when vld&rdy.
- jtlb_sysmap_req_vld  in  1  JTLB refill request valid.
- jtlb_sysmap_req_pa  in  PPN_W  JTLB page number.
- jtlb_sysmap_req_rdy  out  1  JTLB request accepted when vld&rdy.
- mmu_sysmap_pa_y  out  PPN_W  registered page number to sysmap comparators.
- sysmap_mmu_flg_y  in  FLG_WIDTH  combinational flags from sysmap.
- sysmap_mmu_hit_y  in  ENTRY_NUM  combinational one-hot region hit from sysmap.
- sysmap_flush  in  1  kill in-flight lookup/response.
- sysmap_rsp_vld  out  1  response valid.
- sysmap_rsp_rdy  in  1  consumer accepts response when vld&rdy.
- sysmap_rsp_id  out  1  0 = PTW, 1 = JTLB.
- sysmap_rsp_flg  out  FLG_WIDTH  captured flags.
- sysmap_rsp_hit_idx  out  3  encoded index of lowest set hit bit.
- sysmap_rsp_miss  out  1  captured hit vector was all-zero.

## Operation
- FSM states: IDLE, LOOKUP, RESP. Reset state IDLE.
- IDLE: grant one requester (see arbitration) -> load mmu_sysmap_pa_y and id register -> LOOKUP.
- LOOKUP: sample sysmap_mmu_flg_y/hit_y at the clock edge into the response registers -> RESP. Lookup occupies exactly one cycle and cannot stall.
- RESP: sysmap_rsp_vld=1; payload held stable until handshake.
  - If rsp_rdy=0, stay in RESP.
  - If rsp_rdy=1 and no request is granted, go to IDLE.
  - If rsp_rdy=1 and a request is granted, load the new PA and go to LOOKUP (back-to-back).
- req_rdy: high only for the granted requester, only in IDLE or in RESP with rsp_rdy=1, and never while cpurst or sysmap_flush is high.
- Arbitration: round-robin pointer, reset value 0 (PTW priority).
  - Sole requester wins regardless of pointer.
  - When both request, the pointer side wins; the pointer toggles only on a contested grant.
- Hit encode: hit_idx = index of the lowest set bit; miss=1 iff hit==0. Multiple set bits are legal, and the lowest index wins.
- Flush:
  - In LOOKUP or RESP: discard, next state IDLE, rsp_vld=0 next cycle.
  - If flush and rsp handshake coincide, the handshake completes (response consumed), no new grant that cycle, next state IDLE.
  - Flush in IDLE blocks grant only.
- Reset mid-operation: every state register returns to its reset value at the next edge. No response is produced for the in-flight request.

## Timing
- Accept at edge T (vld&rdy high in cycle T-1... i.e. sampled at edge T).
  - mmu_sysmap_pa_y valid in cycle T+1 (LOOKUP).
  - rsp_vld high in cycle T+2.
  - Latency is 2 cycles.
- Peak throughput: one request per 2 cycles (RESP->LOOKUP overlap).
- Reset values: state IDLE, mmu_sysmap_pa_y 0, rsp_vld 0, rsp_id 0, rsp_flg 0, rsp_hit_idx 0, rsp_miss 0, RR pointer 0. Both req_rdy are 0 during reset.
- mmu_sysmap_pa_y holds its last value outside LOOKUP; no combinational path from requester PA to it.
- req_rdy is combinational from state, rsp_rdy, flush and the vld inputs. No rdy depends on sysmap_mmu_* inputs.

## Test plan
- Single PTW request, pa=28'h0000123, bench drives flg=5'b01111, hit=8'h04, rsp_rdy=1 -> rsp_vld at T+2 with id=0, flg=01111, hit_idx=2, miss=0; back to IDLE.
- PTW and JTLB both valid every cycle, rsp_rdy=1 -> grants alternate PTW, JTLB, PTW, JTLB; one response per 2 cycles; ids 0,1,0,1.
- JTLB request with hit=8'h00, rsp_rdy held 0 for 5 cycles -> rsp_vld stays 1, payload stable, miss=1, both req_rdy=0; release rsp_rdy -> single handshake.
- hit=8'hA0 -> hit_idx=5, miss=0. hit=8'h80 -> hit_idx=7.
- sysmap_flush asserted in LOOKUP -> no rsp_vld. Flush coincident with RESP handshake and pending PTW request -> response consumed, no grant, IDLE next.
- cpurst asserted in RESP -> next cycle rsp_vld=0, state IDLE, RR pointer 0, mmu_sysmap_pa_y=0.
